// File: rtl/avg_pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avg_pool_pkg
//  Description : Shared definitions for the average-pooling operators:
//                fixed-point fraction width, reciprocal helper and the
//                backward-pass state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package avg_pool_pkg;

  // Fraction bits of the Q(DATA_W-16).16 gradient format.
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    TAIL = 2'd2
  } state_e;

  // round(2^FRAC_W / k), computed with integer add-half-then-divide.
  function automatic int unsigned recip(input int unsigned k);
    return ((32'd1 << FRAC_W) + (k >> 1)) / k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_recip_scale.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_recip_scale
//  Description : Combinational fixed-point divide-by-constant: multiplies a
//                signed sample by a Q0.16 reciprocal and shifts back down.
//                AVGPOOL_BWD_RND_EN defined   -> round half up (+2^15).
//                AVGPOOL_BWD_RND_EN undefined -> truncate toward -inf.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_recip_scale
  import avg_pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RECIP  = 16384
) (
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [DATA_W-1:0] data_o
);

  // Two guard bits above the exact product width absorb the rounding add.
  localparam int PW = DATA_W + FRAC_W + 2;
  localparam logic signed [PW-1:0] RECIP_EXT = PW'(RECIP);
`ifdef AVGPOOL_BWD_RND_EN
  localparam logic signed [PW-1:0] RND_TERM = PW'(2 ** (FRAC_W - 1));
`else
  localparam logic signed [PW-1:0] RND_TERM = '0;
`endif

  logic signed [PW-1:0] w_data_ext;
  logic signed [PW-1:0] w_prod;

  assign w_data_ext = {{(PW-DATA_W){data_i[DATA_W-1]}}, data_i};
  assign w_prod     = w_data_ext * RECIP_EXT;
  // |result| never exceeds |data_i|, so the narrowing cast cannot overflow.
  assign data_o     = DATA_W'((w_prod + RND_TERM) >>> FRAC_W);

endmodule
`default_nettype wire

// File: rtl/avg_pool_1d_bwd.sv
`default_nettype none
// ============================================================================
//  Module      : avg_pool_1d_bwd
//  Description : Streaming backward pass of non-overlapping 1D average
//                pooling. Each upstream gradient is scaled by 1/KERNEL and
//                replicated KERNEL times, followed by zero gradients for the
//                uncovered tail of the row. Valid/ready on both sides.
//                Optional macro: AVGPOOL_BWD_RND_EN (round-half-up scaling).
//  Revision    : 1.0 - initial release
// ============================================================================
module avg_pool_1d_bwd
  import avg_pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KERNEL = 4,
  parameter int L_IN   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] input_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] output_data,
  output logic              last_out,
  output logic              busy
);

  localparam int L_OUT  = L_IN / KERNEL;
  localparam int TAIL_N = L_IN - L_OUT * KERNEL;
  localparam int RECIP  = int'(recip(KERNEL));
  localparam int CW     = $clog2(KERNEL + 1);
  localparam int IW     = $clog2(L_OUT + 1);

  localparam logic [CW-1:0] REP_LAST  = CW'(KERNEL - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'((TAIL_N > 0) ? (TAIL_N - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(L_OUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CW-1:0]     rep_q,   rep_d;
  logic [CW-1:0]     tail_q,  tail_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [DATA_W-1:0] w_scaled;

  fxp_recip_scale #(
    .DATA_W (DATA_W),
    .RECIP  (RECIP)
  ) u_scale (
    .data_i (input_data),
    .data_o (w_scaled)
  );

  assign busy = (state_q != IDLE);

  // Next-state, handshake and output decode for the replicate/tail sequencer.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rep_d       = rep_q;
    tail_d      = tail_q;
    idx_d       = idx_q;
    ready_in    = 1'b0;
    valid_out   = 1'b0;
    output_data = '0;
    last_out    = 1'b0;

    case (state_q)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) begin
          data_d  = w_scaled;
          rep_d   = '0;
          state_d = EMIT;
        end
      end

      EMIT: begin
        valid_out   = 1'b1;
        output_data = data_q;
        last_out    = (TAIL_N == 0) && (idx_q == IDX_LAST) && (rep_q == REP_LAST);
        // Open the input only on the final replica of a non-final element so
        // the next gradient can be loaded without a bubble.
        ready_in    = ready_out && (rep_q == REP_LAST) && (idx_q != IDX_LAST);
        if (ready_out) begin
          if (rep_q != REP_LAST) begin
            rep_d = rep_q + 1'b1;
          end else if (idx_q != IDX_LAST) begin
            idx_d = idx_q + 1'b1;
            rep_d = '0;
            if (valid_in) begin
              data_d = w_scaled;
            end else begin
              state_d = IDLE;
            end
          end else if (TAIL_N > 0) begin
            state_d = TAIL;
            tail_d  = '0;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end

      TAIL: begin
        valid_out = 1'b1;
        last_out  = (tail_q == TAIL_LAST);
        if (ready_out) begin
          if (tail_q == TAIL_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            tail_d = tail_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; reset discards any partial row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rep_q   <= '0;
      tail_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rep_q   <= rep_d;
      tail_q  <= tail_d;
      idx_q   <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avg_pool_1d_bwd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avg_pool_1d_bwd
//  Description : Self-checking bench for avg_pool_1d_bwd (KERNEL=4/L_IN=10
//                main instance, KERNEL=3/L_IN=3 secondary instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avg_pool_1d_bwd;

  localparam int DW   = 32;
  localparam int K    = 4;
  localparam int LIN  = 10;
  localparam int LOUT = LIN / K;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          valid_in, ready_in, valid_out, ready_out, last_out, busy;
  logic [DW-1:0] input_data, output_data;
  logic          v3_in, r3_in, v3_out, r3_out, l3_out, b3;
  logic [DW-1:0] d3_in, d3_out;

  avg_pool_1d_bwd #(.DATA_W(DW), .KERNEL(K), .L_IN(LIN)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .input_data(input_data),
    .valid_out(valid_out), .ready_out(ready_out), .output_data(output_data),
    .last_out(last_out), .busy(busy)
  );

  avg_pool_1d_bwd #(.DATA_W(DW), .KERNEL(3), .L_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .valid_in(v3_in), .ready_in(r3_in), .input_data(d3_in),
    .valid_out(v3_out), .ready_out(r3_out), .output_data(d3_out),
    .last_out(l3_out), .busy(b3)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] stim[$];
  logic [31:0] exp_d[$];
  bit          exp_l[$];
  logic [31:0] got_d[$];
  bit          got_l[$];
  int          in_cyc[$];
  int          out_cyc[$];
  int          viol, gaps, vcyc, stalls, timed_out;

  // Reference: gradient * round(2^16/k), optional +2^15, floor-divide by 2^16.
  function automatic logic [31:0] model_scale(input logic [31:0] g, input int k);
    longint r, n, q;
    r = longint'((65536 + k / 2) / k);
    n = longint'($signed(g)) * r;
`ifdef AVGPOOL_BWD_RND_EN
    n = n + 32768;
`endif
    q = n / 65536;
    if ((n % 65536 != 0) && (n < 0)) q = q - 1;
    return q[31:0];
  endfunction

  // Expected row: each gradient scaled and repeated K times, zeros to L_IN.
  task automatic build_expected();
    exp_d.delete();
    exp_l.delete();
    for (int j = 0; j < LOUT; j++)
      for (int r = 0; r < K; r++) exp_d.push_back(model_scale(stim[j], K));
    while (exp_d.size() < LIN) exp_d.push_back(32'h0);
    for (int i = 0; i < LIN; i++) exp_l.push_back(i == LIN - 1);
  endtask

  // Feeds stim[] and collects one full output row. bp_mode: 0 always ready,
  // 1 random ready, 2 repeating 1,0,0,1 pattern. Records stall anomalies.
  task automatic drive_row(input int bp_mode);
    int ii = 0, n = 0, cyc = 0;
    bit seen = 0, pstall = 0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    got_d.delete(); got_l.delete(); in_cyc.delete(); out_cyc.delete();
    viol = 0; gaps = 0; vcyc = 0; stalls = 0; timed_out = 0;
    while (n < LIN) begin
      if (cyc >= 400) begin
        timed_out = 1;
        break;
      end
      valid_in = (ii < stim.size());
      if (valid_in) input_data = stim[ii];
      else input_data = '0;
      case (bp_mode)
        0:       ready_out = 1'b1;
        1:       ready_out = 1'($urandom_range(0, 1));
        default: ready_out = !((cyc % 4 == 1) || (cyc % 4 == 2));
      endcase
      @(negedge clk);
      if (pstall && (!valid_out || output_data !== pd || last_out !== pl)) viol++;
      if (valid_out && !ready_out && ready_in) viol++;
      pstall = valid_out && !ready_out;
      if (pstall) stalls++;
      pd = output_data;
      pl = last_out;
      if (valid_out) begin
        seen = 1;
        vcyc++;
      end else if (seen) begin
        gaps++;
      end
      if (valid_in && ready_in) begin
        in_cyc.push_back(cyc);
        ii++;
      end
      if (valid_out && ready_out) begin
        got_d.push_back(output_data);
        got_l.push_back(last_out);
        out_cyc.push_back(cyc);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid_in   = 1'b0;
    ready_out  = 1'b0;
    input_data = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out); else n_pass++;
    n_total++; if (output_data !== 32'h0) $display("FAIL reset_output_data got %h want 0", output_data); else n_pass++;
    n_total++; if (last_out !== 1'b0) $display("FAIL reset_last_out got %b want 0", last_out); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (ready_in !== 1'b1) $display("FAIL reset_ready_in got %b want 1", ready_in); else n_pass++;
    n_total++; if (v3_out !== 1'b0 || b3 !== 1'b0) $display("FAIL reset_k3 got valid %b busy %b want 0 0", v3_out, b3); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    stim.delete();
    stim.push_back(32'h0004_0000);
    stim.push_back(32'h0008_0000);
    build_expected();
    drive_row(0);
    n_total++; if (got_d.size() != LIN || timed_out != 0) $display("FAIL basic_count got %0d want %0d", got_d.size(), LIN); else n_pass++;
    for (int i = 0; i < LIN && i < got_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL basic_elem[%0d] got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else n_pass++;
    end
    n_total++; if (got_d.size() > 4 && got_d[4] !== 32'h0002_0000) $display("FAIL basic_const got %h want 00020000", got_d[4]); else n_pass++;
    n_total++; if (gaps != 0 || vcyc != LIN) $display("FAIL basic_no_bubble got gaps %0d valid %0d want 0 %0d", gaps, vcyc, LIN); else n_pass++;
  endtask

  task automatic test_rounding();
    stim.delete();
    stim.push_back(32'hFFFF_FFFF);
    stim.push_back($urandom());
    build_expected();
    drive_row(0);
    n_total++; if (got_d.size() != LIN) $display("FAIL round_count got %0d want %0d", got_d.size(), LIN); else n_pass++;
    for (int i = 0; i < K && i < got_d.size(); i++) begin
      n_total++;
`ifdef AVGPOOL_BWD_RND_EN
      if (got_d[i] !== 32'h0000_0000) $display("FAIL round_neg1[%0d] got %h want 00000000", i, got_d[i]);
`else
      if (got_d[i] !== 32'hFFFF_FFFF) $display("FAIL round_neg1[%0d] got %h want ffffffff", i, got_d[i]);
`endif
      else n_pass++;
    end
    for (int i = K; i < LIN && i < got_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL round_elem[%0d] got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_kernel3();
    int n = 0, cyc = 0;
    bit acc;
    logic [31:0] od[3];
    bit ol[3];
    v3_in = 1'b1; d3_in = 32'h0003_0000; r3_out = 1'b1;
    while (n < 3 && cyc < 50) begin
      @(negedge clk);
      if (v3_out && r3_out) begin
        od[n] = d3_out;
        ol[n] = l3_out;
        n++;
      end
      acc = v3_in && r3_in;
      @(posedge clk); #1;
      cyc++;
      if (acc) v3_in = 1'b0;
    end
    r3_out = 1'b0;
    n_total++; if (n != 3) $display("FAIL k3_count got %0d want 3", n); else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (od[i] !== 32'h0000_FFFF || ol[i] !== (i == 2))
        $display("FAIL k3_elem[%0d] got %h/%b want 0000ffff/%b", i, od[i], ol[i], (i == 2));
      else n_pass++;
    end
    n_total++; if (r3_in !== 1'b1 || b3 !== 1'b0) $display("FAIL k3_idle got ready %b busy %b want 1 0", r3_in, b3); else n_pass++;
  endtask

  task automatic test_backpressure();
    stim.delete();
    stim.push_back($urandom());
    stim.push_back($urandom());
    build_expected();
    drive_row(2);
    n_total++; if (got_d.size() != LIN) $display("FAIL bp_count got %0d want %0d", got_d.size(), LIN); else n_pass++;
    for (int i = 0; i < LIN && i < got_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL bp_elem[%0d] got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else n_pass++;
    end
    n_total++; if (viol != 0 || stalls == 0) $display("FAIL bp_stall got violations %0d stalls %0d want 0 >0", viol, stalls); else n_pass++;
  endtask

  task automatic test_random_rows();
    for (int row = 0; row < 4; row++) begin
      stim.delete();
      stim.push_back($urandom());
      stim.push_back($urandom());
      build_expected();
      drive_row(1);
      n_total++; if (got_d.size() != LIN) $display("FAIL rand_count[%0d] got %0d want %0d", row, got_d.size(), LIN); else n_pass++;
      for (int i = 0; i < LIN && i < got_d.size(); i++) begin
        n_total++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
          $display("FAIL rand_elem[%0d][%0d] got %h/%b want %h/%b", row, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        else n_pass++;
      end
      n_total++; if (viol != 0) $display("FAIL rand_stall[%0d] got %0d want 0", row, viol); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1; input_data = 32'h0012_3456; ready_out = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_total++; if (valid_out !== 1'b1) $display("FAIL rstmid_pre got valid %b want 1", valid_out); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (valid_out !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_async got valid %b busy %b want 0 0", valid_out, busy); else n_pass++;
    ready_out = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim.delete();
    stim.push_back($urandom());
    stim.push_back($urandom());
    build_expected();
    drive_row(0);
    n_total++; if (got_d.size() != LIN) $display("FAIL rstmid_count got %0d want %0d", got_d.size(), LIN); else n_pass++;
    for (int i = 0; i < LIN && i < got_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL rstmid_elem[%0d] got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    stim.delete();
    stim.push_back($urandom());
    stim.push_back($urandom());
    build_expected();
    drive_row(0);
    n_total++;
    if (in_cyc.size() != 2 || out_cyc.size() < K)
      $display("FAIL b2b_handoff got %0d inputs %0d outputs want 2 >=%0d", in_cyc.size(), out_cyc.size(), K);
    else if (in_cyc[1] != out_cyc[K-1])
      $display("FAIL b2b_handoff got input cycle %0d want %0d", in_cyc[1], out_cyc[K-1]);
    else n_pass++;
    n_total++; if (gaps != 0) $display("FAIL b2b_gaps got %0d want 0", gaps); else n_pass++;
    for (int i = 0; i < LIN && i < got_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL b2b_elem[%0d] got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  initial begin
    valid_in = 1'b0; ready_out = 1'b0; input_data = '0;
    v3_in = 1'b0; r3_out = 1'b0; d3_in = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_kernel3();
    test_backpressure();
    test_random_rows();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
